// File: rtl/mux_sel_arbiter.sv
// rtl/mux_sel_arbiter.sv - round-robin select generator for a 4:1 mux (MUX_SEL_FIXED_PRIO_EN selects fixed priority)
module mux_sel_arbiter #(
    parameter int TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       done,
    output logic [1:0] s,
    output logic [3:0] gnt,
    output logic       valid,
    output logic       timeout
);

    localparam int TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    logic [0:0]    state;
    logic [1:0]    last;
    logic [TW-1:0] timer;
    logic [1:0]    sel;
    logic          any_req;
    logic          normal_rel;
    logic          forced_rel;

`ifdef MUX_SEL_FIXED_PRIO_EN
    // Lowest index wins; scanning downward lets the last hit be the winner.
    always_comb begin
        sel = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (req[i]) sel = 2'(i);
        end
    end
`else
    always_comb begin
        logic found;
        sel   = 2'd0;
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            if (!found && req[last + 2'(k)]) begin
                sel   = last + 2'(k);
                found = 1'b1;
            end
        end
    end
`endif

    assign any_req    = |req;
    assign normal_rel = done || !req[s];
    assign forced_rel = (TIMEOUT != 0) && (timer == TMAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            last    <= 2'd3;
            timer   <= '0;
            s       <= 2'd0;
            gnt     <= 4'b0000;
            valid   <= 1'b0;
            timeout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    timeout <= 1'b0;
                    if (any_req) begin
                        s     <= sel;
                        gnt   <= 4'b0001 << sel;
                        valid <= 1'b1;
                        timer <= TW'(1);
                        state <= BUSY;
                    end else begin
                        gnt   <= 4'b0000;
                        valid <= 1'b0;
                        timer <= '0;
                    end
                end
                BUSY: begin
                    if (normal_rel || forced_rel) begin
                        state   <= IDLE;
                        valid   <= 1'b0;
                        gnt     <= 4'b0000;
                        last    <= s;
                        timer   <= '0;
                        // done or a withdrawn request outranks expiry, so no pulse then
                        timeout <= !normal_rel;
                    end else begin
                        timer   <= timer + TW'(1);
                        timeout <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    valid   <= 1'b0;
                    gnt     <= 4'b0000;
                    timer   <= '0;
                    timeout <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// tb/tb_mux_sel_arbiter.sv - scoreboard bench for mux_sel_arbiter with TIMEOUT=4
module tb_mux_sel_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic       done;
    logic [1:0] s;
    logic [3:0] gnt;
    logic       valid;
    logic       timeout;

    int n_total = 0;
    int n_pass  = 0;
    int exp_q[$];
    int m_last  = 3;
    int e;
    int cnt;
    logic prev_valid = 1'b0;

    mux_sel_arbiter #(.TIMEOUT(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .done    (done),
        .s       (s),
        .gnt     (gnt),
        .valid   (valid),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        else
            n_pass++;
    endtask

    // Reference arbitration: which channel should win for a given request vector
    function automatic int pick(input logic [3:0] r);
`ifdef MUX_SEL_FIXED_PRIO_EN
        for (int i = 0; i < 4; i++)
            if (r[i]) return i;
`else
        for (int k = 1; k <= 4; k++)
            if (r[(m_last + k) % 4]) return (m_last + k) % 4;
`endif
        return -1;
    endfunction

    task automatic expect_grant(input logic [3:0] r);
        int p;
        p = pick(r);
        exp_q.push_back(p);
        m_last = p;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (valid) return;
        end
        check("grant_wait", valid, 1);
    endtask

    task automatic release_done();
        tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        @(negedge clk);
        check("gap_valid", valid, 0);
        check("gap_timeout", timeout, 0);
    endtask

    always @(negedge clk) begin
        if (valid && !prev_valid) begin
            if (exp_q.size() == 0) begin
                check("sb_underflow", exp_q.size(), 1);
            end else begin
                e = exp_q.pop_front();
                check("grant_s", s, e);
                check("grant_gnt", gnt, 4'b0001 << e);
            end
        end
        prev_valid = valid;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst  = 1'b1;
        req  = 4'b0000;
        done = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_s", s, 0);
        check("rst_gnt", gnt, 0);
        check("rst_valid", valid, 0);
        check("rst_timeout", timeout, 0);
        tick();
        rst = 1'b0;

        // grant ch2, then reset asynchronously mid-grant
        req = 4'b0100;
        expect_grant(req);
        wait_grant();
        #2;
        rst = 1'b1;
        #1;
        check("async_s", s, 0);
        check("async_gnt", gnt, 0);
        check("async_valid", valid, 0);
        m_last = 3;
        req = 4'b1111;
        tick();
        rst = 1'b0;

        // round robin with all requesting
        expect_grant(req);
        wait_grant();
        release_done();
        for (int i = 0; i < 4; i++) begin
            expect_grant(req);
            @(negedge clk);
            check("b2b_valid", valid, 1);
            release_done();
        end
        req = 4'b0000;

        // single requester, latency and regrant
        tick();
        req = 4'b0100;
        expect_grant(req);
        @(negedge clk);
        check("lat_before", valid, 0);
        @(negedge clk);
        check("lat_after", valid, 1);
        release_done();
        expect_grant(req);
        @(negedge clk);
        check("regrant_valid", valid, 1);
        release_done();
        req = 4'b0000;

        // forced release
        tick();
        req = 4'b0001;
        expect_grant(req);
        wait_grant();
        cnt = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!valid) break;
            cnt++;
        end
        check("to_cycles", cnt, 4);
        check("to_pulse", timeout, 1);
        req = 4'b0000;
        @(negedge clk);
        check("to_pulse_end", timeout, 0);

        // done on the last permitted cycle wins over expiry
        tick();
        req = 4'b0001;
        expect_grant(req);
        wait_grant();
        repeat (3) @(negedge clk);
        check("to4_valid", valid, 1);
        done = 1'b1;
        tick();
        done = 1'b0;
        req  = 4'b0000;
        @(negedge clk);
        check("to4_valid_rel", valid, 0);
        check("to4_no_pulse", timeout, 0);

        // withdraw the granted request
        tick();
        req = 4'b1001;
        expect_grant(req);
        wait_grant();
        req = 4'b0001;
        @(negedge clk);
        check("wd_valid", valid, 0);
        check("wd_timeout", timeout, 0);
        expect_grant(req);
        @(negedge clk);
        check("wd_next_valid", valid, 1);
        release_done();
        req = 4'b0000;

        // two requesters: alternate in round robin, ch1 always in fixed priority
        tick();
        req = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            expect_grant(req);
            wait_grant();
            release_done();
        end
        req = 4'b0000;

        repeat (3) @(negedge clk);
        check("sb_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
